// File: rtl/cl_pkg.sv
// Shared constants for the bit-serial logic-cell driver: cell opcodes and FSM encoding.
package cl_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cl_serial_driver_if.sv
// Word-level start/done handshake between datapath control and the serial driver.
interface cl_serial_driver_if #(
    parameter int unsigned N = 8
);

    logic         start;
    logic [1:0]   op;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, op, x, y,
        input  busy, done, result
    );

    modport slave (
        input  start, op, x, y,
        output busy, done, result
    );

endinterface

// File: rtl/cl_bit_shreg.sv
// N-bit register with synchronous clear and single-bit indexed write; holds the result word.
module cl_bit_shreg #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_bit,
    output logic [N-1:0]     q
);

    logic [N-1:0] data_q;
    logic [N-1:0] data_d;

    // Clear wins over a write; otherwise update only the addressed bit.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (wr_en) begin
            data_d[wr_idx] = wr_bit;
        end
    end

    // Result storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/cl_serial_driver.sv
// Bit-serial driver: streams two latched words LSB first through a 1-bit logic cell and
// gathers the cell output into a result word.
module cl_serial_driver
    import cl_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cl_serial_driver_if.slave     bus,
    output logic                  cell_a,
    output logic                  cell_b,
    output logic [1:0]            cell_s,
    input  logic                  cell_out
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       xa_q, xa_d;
    logic [N-1:0]       yb_q, yb_d;
    logic [1:0]         op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cell_a_q, cell_a_d;
    logic               cell_b_q, cell_b_d;
    logic [1:0]         cell_s_q, cell_s_d;
    logic               res_clr;
    logic               res_wr;

    // Next state, operand latch, counter and registered cell drive.
    // Cell drive is computed from the next state/counter so the flops present bit i
    // throughout the RUN cycle whose counter is i.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xa_d     = xa_q;
        yb_d     = yb_q;
        op_d     = op_q;
        res_clr  = 1'b0;
        res_wr   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = ST_RUN;
                    xa_d    = bus.x;
                    yb_d    = bus.y;
                    op_d    = bus.op;
                    res_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_wr = 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d   = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
        cell_a_d = busy_d ? xa_d[cnt_d] : 1'b0;
        cell_b_d = busy_d ? yb_d[cnt_d] : 1'b0;
        cell_s_d = busy_d ? op_d : 2'b00;
    end

    // Control and drive registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            xa_q     <= '0;
            yb_q     <= '0;
            op_q     <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cell_a_q <= 1'b0;
            cell_b_q <= 1'b0;
            cell_s_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            xa_q     <= xa_d;
            yb_q     <= yb_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cell_a_q <= cell_a_d;
            cell_b_q <= cell_b_d;
            cell_s_q <= cell_s_d;
        end
    end

    // Result word: cleared on an accepted start, bit cnt_q captured from the cell each RUN cycle.
    cl_bit_shreg #(
        .N     (N),
        .IDX_W (CNT_W)
    ) u_result (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (res_clr),
        .wr_en  (res_wr),
        .wr_idx (cnt_q),
        .wr_bit (cell_out),
        .q      (bus.result)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign cell_a   = cell_a_q;
    assign cell_b   = cell_b_q;
    assign cell_s   = cell_s_q;

endmodule

// File: tb/tb_cl_serial_driver.sv
// Bench for cl_serial_driver: word-level timeline model plus directed scenarios.
module tb_cl_serial_driver;

    localparam int unsigned N = 8;

    logic       clk;
    logic       rst_n;
    logic       cell_a;
    logic       cell_b;
    logic [1:0] cell_s;
    logic       cell_out;

    cl_serial_driver_if #(.N(N)) bus ();

    cl_serial_driver #(.N(N), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cell_a   (cell_a),
        .cell_b   (cell_b),
        .cell_s   (cell_s),
        .cell_out (cell_out)
    );

    // The real 1-bit logic cell.
    always_comb begin
        case (cell_s)
            2'b00:   cell_out = cell_a & cell_b;
            2'b01:   cell_out = cell_a | cell_b;
            2'b10:   cell_out = cell_a ^ cell_b;
            default: cell_out = ~cell_a;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] word_fn(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Timeline model: a word accepted at edge s occupies cycles s..s+N-1, done in s+N.
    int         cyc_r = 0;
    int         m_cyc = 0;
    bit         m_have = 0;
    int         m_s = 0;
    logic [7:0] m_x, m_y, m_full;
    logic [1:0] m_op;

    always @(posedge clk) cyc_r <= cyc_r + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have = 0;
            m_full = 8'h00;
        end else begin
            m_cyc = m_cyc + 1;
            if (bus.start && (!m_have || m_cyc >= m_s + N + 1)) begin
                m_have = 1;
                m_s    = m_cyc;
                m_x    = bus.x;
                m_y    = bus.y;
                m_op   = bus.op;
                m_full = word_fn(bus.op, bus.x, bus.y);
            end
        end
    end

    bit chk_en = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    // Per-cycle comparison of every output against the timeline model.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int   j      = m_cyc;
            automatic bit   busy_e = m_have && (j >= m_s) && (j <= m_s + N - 1);
            automatic bit   done_e = m_have && (j == m_s + N);
            automatic logic [7:0] res_e;
            automatic logic [31:0] mask;
            if (!m_have) res_e = 8'h00;
            else if (busy_e) begin
                mask  = (32'd1 << (j - m_s)) - 32'd1;
                res_e = m_full & mask[7:0];
            end else res_e = m_full;
            check("busy",   32'(bus.busy),   32'(busy_e));
            check("done",   32'(bus.done),   32'(done_e));
            check("result", 32'(bus.result), 32'(res_e));
            check("cell_a", 32'(cell_a), busy_e ? 32'(m_x[j - m_s]) : 32'd0);
            check("cell_b", 32'(cell_b), busy_e ? 32'(m_y[j - m_s]) : 32'd0);
            check("cell_s", 32'(cell_s), busy_e ? 32'(m_op) : 32'd0);
        end
        if (bus.done) done_cnt++;
        if (bus.busy) busy_cnt++;
    end

    task automatic wait_done(output int at_cyc);
        bit found = 0;
        at_cyc = -1;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus.done) begin
                found  = 1;
                at_cyc = cyc_r;
            end
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Pulse start for one cycle with the given word, then wait for done.
    task automatic run_word(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            output int start_cyc, output int done_cyc);
        @(negedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.x = a; bus.y = b;
        start_cyc = cyc_r;
        @(negedge clk); #1;
        bus.start = 1'b0;
        wait_done(done_cyc);
    endtask

    int sc, dc, d1, d2;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.x = 8'h00; bus.y = 8'h00;
        #2;
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_result", 32'(bus.result), 32'h00);
        check("rst_cell_s", 32'(cell_s),     32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1;
        repeat (2) @(negedge clk);

        // 1: AND, latency and busy window
        busy_cnt = 0; done_cnt = 0;
        run_word(2'b00, 8'hF0, 8'h3C, sc, dc);
        check("t1_result",  32'(bus.result), 32'h30);
        check("t1_latency", 32'(dc - sc),    32'd9);
        repeat (2) @(negedge clk);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd8);
        check("t1_done_pulses", 32'(done_cnt), 32'd1);

        // 2: OR
        run_word(2'b01, 8'hA5, 8'h0F, sc, dc);
        check("t2_result", 32'(bus.result), 32'hAF);
        @(negedge clk);
        check("t2_idle_cell_s", 32'(cell_s), 32'd0);

        // 3: XOR then NOT
        run_word(2'b10, 8'hFF, 8'h55, sc, dc);
        check("t3_xor_result", 32'(bus.result), 32'hAA);
        run_word(2'b11, 8'h0F, 8'hFF, sc, dc);
        check("t3_not_result", 32'(bus.result), 32'hF0);

        // 4: start during RUN is ignored
        repeat (2) @(negedge clk);
        done_cnt = 0;
        @(negedge clk); #1;
        bus.start = 1'b1; bus.op = 2'b01; bus.x = 8'h81; bus.y = 8'h18;
        @(negedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk); #1;
        bus.start = 1'b1; bus.x = 8'h00; bus.y = 8'h00;
        @(negedge clk); #1;
        bus.start = 1'b0;
        wait_done(dc);
        check("t4_result", 32'(bus.result), 32'h99);
        repeat (12) @(negedge clk);
        check("t4_done_pulses", 32'(done_cnt), 32'd1);

        // 5: asynchronous reset mid-word
        @(negedge clk); #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.x = 8'hFF; bus.y = 8'h00;
        @(negedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_pre_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy",   32'(bus.busy),   32'd0);
        check("t5_result", 32'(bus.result), 32'h00);
        check("t5_cell_a", 32'(cell_a),     32'd0);
        check("t5_cell_s", 32'(cell_s),     32'd0);
        done_cnt = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_no_done", 32'(done_cnt), 32'd0);
        run_word(2'b00, 8'hF0, 8'h3C, sc, dc);
        check("t5_next_result", 32'(bus.result), 32'h30);

        // 6: start held through DONE chains a second word with no IDLE gap
        @(negedge clk); #1;
        bus.start = 1'b1; bus.op = 2'b00; bus.x = 8'hF0; bus.y = 8'h3C;
        wait_done(d1);
        #1;
        bus.op = 2'b10; bus.x = 8'h12; bus.y = 8'h34;
        @(negedge clk); #1;
        bus.start = 1'b0;
        check("t6_second_busy", 32'(bus.busy), 32'd1);
        wait_done(d2);
        check("t6_result",  32'(bus.result), 32'h26);
        check("t6_spacing", 32'(d2 - d1),    32'd9);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
